// File: rtl/volume_ctrl_axil_slave.sv
// AXI4-Lite register slave for the volume control IP: four 32-bit registers plus
// frame-synchronised shadow copies that drive the audio datapath gain/mute.
module volume_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int VOL_W              = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  input  logic                            frame_strobe,
  output logic [VOL_W-1:0]                vol_l,
  output logic [VOL_W-1:0]                vol_r,
  output logic                            mute,
  output logic                            cfg_pending
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;

  wr_state_t wr_state, wr_next;
  logic      wr_fire;
  logic      aw_hs, w_hs, ar_hs;
  logic [1:0]  aw_idx_q, wr_idx;
  logic [31:0] w_data_q, wr_data;
  logic [3:0]  w_strb_q, wr_strb;
  logic [31:0] regs [4];
  logic        cfg_wr, bypass_next;
  logic        unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs = s00_axi_awvalid & s00_axi_awready;
  assign w_hs  = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs = s00_axi_arvalid & s00_axi_arready;

  assign s00_axi_bresp  = '0;
  assign s00_axi_rresp  = '0;
  assign s00_axi_bvalid = (wr_state == W_RESP);

  always_comb begin
    wr_next = wr_state;
    wr_fire = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next = W_RESP;
          wr_fire = 1'b1;
        end else if (aw_hs) begin
          wr_next = W_HAVE_AW;
        end else if (w_hs) begin
          wr_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) begin
        wr_next = W_RESP;
        wr_fire = 1'b1;
      end
      W_HAVE_W: if (aw_hs) begin
        wr_next = W_RESP;
        wr_fire = 1'b1;
      end
      W_RESP: if (s00_axi_bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // The second channel to arrive is used straight from the bus, the first from its latch.
  assign wr_idx  = aw_hs ? s00_axi_awaddr[3:2] : aw_idx_q;
  assign wr_data = w_hs ? s00_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? s00_axi_wstrb : w_strb_q;

  assign cfg_wr      = wr_fire && (wr_idx != 2'd3) && (|wr_strb);
  assign bypass_next = (wr_fire && wr_idx == 2'd0 && wr_strb[0]) ? wr_data[1] : regs[0][1];

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state        <= W_IDLE;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      aw_idx_q        <= '0;
      w_data_q        <= '0;
      w_strb_q        <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      wr_state        <= wr_next;
      s00_axi_awready <= (wr_next == W_IDLE) || (wr_next == W_HAVE_W);
      s00_axi_wready  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_AW);
      if (aw_hs) aw_idx_q <= s00_axi_awaddr[3:2];
      if (w_hs) begin
        w_data_q <= s00_axi_wdata;
        w_strb_q <= s00_axi_wstrb;
      end
      if (wr_fire) begin
        for (int unsigned b = 0; b < 4; b++)
          if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else if (ar_hs) begin
      s00_axi_rdata   <= regs[s00_axi_araddr[3:2]];
      s00_axi_rvalid  <= 1'b1;
      s00_axi_arready <= 1'b0;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid  <= 1'b0;
      s00_axi_arready <= 1'b1;
    end else begin
      s00_axi_arready <= ~s00_axi_rvalid;
    end
  end

  // Shadows sample the registers before this cycle's write; a same-cycle write re-arms pending.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      vol_l       <= '0;
      vol_r       <= '0;
      mute        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      if (regs[0][1] || (frame_strobe && cfg_pending)) begin
        vol_l       <= regs[1][VOL_W-1:0];
        vol_r       <= regs[2][VOL_W-1:0];
        mute        <= regs[0][0];
        cfg_pending <= 1'b0;
      end
      if (cfg_wr) cfg_pending <= ~bypass_next;
    end
  end

endmodule

// File: tb/tb_volume_ctrl_axil_slave.sv
// Directed self-checking bench for volume_ctrl_axil_slave: register map, byte strobes,
// channel ordering, back-pressure, frame-synchronised shadows, bypass and reset.
module tb_volume_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        frame_strobe;
  logic [15:0] vol_l, vol_r;
  logic        mute, cfg_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  volume_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .VOL_W(16)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .frame_strobe(frame_strobe), .vol_l(vol_l), .vol_r(vol_r), .mute(mute), .cfg_pending(cfg_pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic aw_done, w_done, aw_go, w_go;
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0; resp = 2'b11;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick();
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid = 1'b0;  w_done = 1'b1;  end
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required=1", a, bvalid);
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      resp = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; n = 0; d = 'x; resp = 2'b11;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required=1", a, rvalid);
    end else begin
      d = rdata; resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic pulse_strobe();
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick(); tick();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'h0 ||
        vol_l !== 16'h0 || vol_r !== 16'h0 || mute !== 1'b0 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_state aw/w/ar/b/r=%b rdata=%h vol_l=%h vol_r=%h mute=%b pend=%b required all 0",
               {awready, wready, arready, bvalid, rvalid}, rdata, vol_l, vol_r, mute, cfg_pending);
    end
    areset = 1'b0;
    tick();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset aw/w/ar=%b required=111", {awready, wready, arready});
    end
  endtask

  task automatic test_regmap();
    logic [1:0]  resp;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, resp);
      checks++;
      if (resp !== 2'b00) begin
        errors++;
        $display("FAIL regmap_bresp[%0d] got=%b required=00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp);
      checks++;
      if (d !== 32'(i + 1) || resp !== 2'b00) begin
        errors++;
        $display("FAIL regmap_read[%0d] got=%h/%b required=%h/00", i, d, resp, i + 1);
      end
    end
  endtask

  task automatic test_wstrb();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(4'h4, 32'h11223344, 4'hF, resp);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, resp);
    axi_read(4'h4, d, resp);
    checks++;
    if (d !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL wstrb_merge got=%h required=11bb33dd", d);
    end
    axi_write(4'hE, 32'hCAFEF00D, 4'hF, resp);
    axi_read(4'hD, d, resp);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL unaligned_addr got=%h required=cafef00d", d);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  resp;
    logic [31:0] d;
    awaddr = 4'hC; wdata = 32'h00005A5A; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_alone wready=%b awready=%b bvalid=%b required=0/1/0", wready, awready, bvalid);
    end
    tick(); tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL bvalid_after_aw got=%b required=1", bvalid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL b_backpressure[%0d] bvalid=%b awready=%b wready=%b required=1/0/0",
                 i, bvalid, awready, wready);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL b_release bvalid=%b awready=%b wready=%b required=0/1/1", bvalid, awready, wready);
    end
    axi_read(4'hC, d, resp);
    checks++;
    if (d !== 32'h00005A5A) begin
      errors++;
      $display("FAIL w_first_data got=%h required=00005a5a", d);
    end
  endtask

  task automatic test_shadow();
    logic [1:0] resp;
    pulse_strobe();
    checks++;
    if (vol_l !== 16'h33DD || vol_r !== 16'h0003 || mute !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL shadow_apply vol_l=%h vol_r=%h mute=%b pend=%b required=33dd/0003/1/0",
               vol_l, vol_r, mute, cfg_pending);
    end
    axi_write(4'h8, 32'h00000800, 4'hF, resp);
    checks++;
    if (cfg_pending !== 1'b1 || vol_r !== 16'h0003) begin
      errors++;
      $display("FAIL shadow_hold pend=%b vol_r=%h required=1/0003", cfg_pending, vol_r);
    end
    pulse_strobe();
    checks++;
    if (cfg_pending !== 1'b0 || vol_r !== 16'h0800) begin
      errors++;
      $display("FAIL shadow_update pend=%b vol_r=%h required=0/0800", cfg_pending, vol_r);
    end
    awaddr = 4'h8; wdata = 32'h00000100; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; frame_strobe = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; frame_strobe = 1'b0;
    checks++;
    if (cfg_pending !== 1'b1 || vol_r !== 16'h0800 || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_with_strobe pend=%b vol_r=%h bvalid=%b required=1/0800/1",
               cfg_pending, vol_r, bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    pulse_strobe();
    checks++;
    if (vol_r !== 16'h0100 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL deferred_apply vol_r=%h pend=%b required=0100/0", vol_r, cfg_pending);
    end
  endtask

  task automatic test_bypass();
    logic [1:0] resp;
    axi_write(4'h0, 32'h0, 4'hF, resp);
    pulse_strobe();
    checks++;
    if (mute !== 1'b0) begin
      errors++;
      $display("FAIL unmute got=%b required=0", mute);
    end
    axi_write(4'h0, 32'h3, 4'hF, resp);
    checks++;
    if (mute !== 1'b1 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL bypass_mute mute=%b pend=%b required=1/0", mute, cfg_pending);
    end
    axi_write(4'h4, 32'h00001234, 4'hF, resp);
    checks++;
    if (vol_l !== 16'h1234 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL bypass_vol_l vol_l=%h pend=%b required=1234/0", vol_l, cfg_pending);
    end
  endtask

  task automatic test_reset_inflight();
    logic [1:0]  resp;
    logic [31:0] d;
    awaddr = 4'h4; wdata = 32'hFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h0; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h3) begin
      errors++;
      $display("FAIL inflight bvalid=%b rvalid=%b rdata=%h required=1/1/00000003", bvalid, rvalid, rdata);
    end
    areset = 1'b1;
    tick();
    checks++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || vol_l !== 16'h0 || mute !== 1'b0 || cfg_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_inflight bvalid=%b rvalid=%b vol_l=%h mute=%b pend=%b required=0/0/0000/0/0",
               bvalid, rvalid, vol_l, mute, cfg_pending);
    end
    areset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, resp);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reg_after_reset[%0d] got=%h required=00000000", i, d);
      end
    end
  endtask

  initial begin
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    frame_strobe = 1'b0; areset = 1'b1;
    test_reset();
    test_regmap();
    test_wstrb();
    test_w_before_aw();
    test_shadow();
    test_bypass();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
